// File: rtl/pin_test_array.sv
// WIDTH-channel pin test block: synchronised inverting path plus a start-triggered
// walking-one / LFSR pattern engine with a loopback check and saturating error count.
module pin_test_array #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RUN_LEN     = 64,
  parameter int unsigned CNT_W       = 8,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_i,
  input  logic [1:0]       mode_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] tied_to_one_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             err_sat_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0]       M_WALK    = 2'b01;
  localparam logic [1:0]       M_LFSR    = 2'b10;
  localparam logic [1:0]       M_CHECK   = 2'b11;
  localparam logic [31:0]      LAST_CNT  = 32'(RUN_LEN - 1);
  localparam logic [31:0]      FILL_CNT  = 32'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;
  localparam logic [WIDTH-1:0] WALK_INIT = WIDTH'(1);

  state_t                             state_q;
  logic [1:0]                         mode_q;
  logic [31:0]                        cnt_q;
  logic [31:0]                        lfsr_q;
  logic [WIDTH-1:0]                   walk_q;
  logic [WIDTH-1:0]                   out_q;
  logic                               busy_q;
  logic                               done_q;
  logic [CNT_W-1:0]                   err_q;
  logic                               err_sat_q;
  logic [SYNC_STAGES:0][WIDTH-1:0]    dly_q;

  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] walk_rot;
  logic [31:0]      lfsr_adv;
  logic [CNT_W-1:0] err_inc;
  logic             start_acc;
  logic             run_last;
  logic             mismatch;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sh_q;
      if (SYNC_STAGES == 1) begin : g_one
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sh_q <= '0;
          else        sh_q <= in_i[gi];
        end
      end else begin : g_multi
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sh_q <= '0;
          else        sh_q <= {sh_q[SYNC_STAGES-2:0], in_i[gi]};
        end
      end
      assign in_s[gi] = sh_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    start_acc = start_i && (state_q != S_RUN);
    run_last  = (cnt_q == LAST_CNT);
    walk_rot  = {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
    lfsr_adv  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    err_inc   = err_q + CNT_W'(1);
    // The oldest delay-line entry is what a loopback pin shows after the synchroniser.
    mismatch  = (state_q == S_RUN) && (mode_q == M_CHECK) && (cnt_q >= FILL_CNT) &&
                (in_s != dly_q[SYNC_STAGES]);
    out_d     = ~in_s;
    case (state_q)
      S_RUN: begin
        if (run_last) begin
          out_d = '0;
        end else begin
          case (mode_q)
            M_WALK:          out_d = walk_rot;
            M_LFSR, M_CHECK: out_d = lfsr_adv[WIDTH-1:0];
            default:         out_d = ~in_s;
          endcase
        end
      end
      default: begin
        if (start_acc) begin
          case (mode_i)
            M_WALK:          out_d = WALK_INIT;
            M_LFSR, M_CHECK: out_d = LFSR_SEED[WIDTH-1:0];
            default:         out_d = ~in_s;
          endcase
        end else if (state_q == S_DONE) begin
          out_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'b00;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      walk_q    <= WALK_INIT;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      err_sat_q <= 1'b0;
    end else begin
      out_q <= out_d;
      case (state_q)
        S_RUN: begin
          cnt_q  <= cnt_q + 32'd1;
          lfsr_q <= lfsr_adv;
          walk_q <= walk_rot;
          if (mismatch && (err_q != ERR_MAX)) begin
            err_q <= err_inc;
            if (err_inc == ERR_MAX) err_sat_q <= 1'b1;
          end
          if (run_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (start_acc) begin
            state_q   <= S_RUN;
            mode_q    <= mode_i;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            walk_q    <= WALK_INIT;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= '0;
            err_sat_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly_q <= '0;
    else        dly_q <= {dly_q[SYNC_STAGES-1:0], out_d};
  end

  assign out_o         = out_q;
  assign tied_to_one_o = '1;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_count_o   = err_q;
  assign err_sat_o     = err_sat_q;

endmodule

// File: tb/tb_pin_test_array.sv
// Directed bench for pin_test_array: four instances (RUN_LEN 10/64/64/1, CNT_W 8/8/4/8)
// share stimulus; expected pin values are queued before each run and popped per cycle.
module tb_pin_test_array;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam int          SS   = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, loop_en;
  logic [1:0] mode;
  logic [7:0] in_drv;
  logic [7:0] in_a, in_b, in_c, in_d;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic [7:0] tie_a, tie_b, tie_c, tie_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       done_a, done_b, done_c, done_d;
  logic [7:0] err_a, err_b, err_d;
  logic [3:0] err_c;
  logic       sat_a, sat_b, sat_c, sat_d;

  int n_pass = 0, n_fail = 0, n_checks = 0;
  logic [31:0] sb_q[$];
  int m64, m10, guard;

  always #5 clk = ~clk;

  assign in_a = loop_en ? out_a : in_drv;
  assign in_b = loop_en ? out_b : in_drv;
  assign in_c = loop_en ? out_c : in_drv;
  assign in_d = loop_en ? out_d : in_drv;

  pin_test_array #(.WIDTH(8), .SYNC_STAGES(SS), .RUN_LEN(10), .CNT_W(8), .LFSR_SEED(SEED)) u_a (
    .clk(clk), .rst_n(rst_n), .in_i(in_a), .mode_i(mode), .start_i(start), .out_o(out_a),
    .tied_to_one_o(tie_a), .busy_o(busy_a), .done_o(done_a), .err_count_o(err_a), .err_sat_o(sat_a));
  pin_test_array #(.WIDTH(8), .SYNC_STAGES(SS), .RUN_LEN(64), .CNT_W(8), .LFSR_SEED(SEED)) u_b (
    .clk(clk), .rst_n(rst_n), .in_i(in_b), .mode_i(mode), .start_i(start), .out_o(out_b),
    .tied_to_one_o(tie_b), .busy_o(busy_b), .done_o(done_b), .err_count_o(err_b), .err_sat_o(sat_b));
  pin_test_array #(.WIDTH(8), .SYNC_STAGES(SS), .RUN_LEN(64), .CNT_W(4), .LFSR_SEED(SEED)) u_c (
    .clk(clk), .rst_n(rst_n), .in_i(in_c), .mode_i(mode), .start_i(start), .out_o(out_c),
    .tied_to_one_o(tie_c), .busy_o(busy_c), .done_o(done_c), .err_count_o(err_c), .err_sat_o(sat_c));
  pin_test_array #(.WIDTH(8), .SYNC_STAGES(SS), .RUN_LEN(1), .CNT_W(8), .LFSR_SEED(SEED)) u_d (
    .clk(clk), .rst_n(rst_n), .in_i(in_d), .mode_i(mode), .start_i(start), .out_o(out_d),
    .tied_to_one_o(tie_d), .busy_o(busy_d), .done_o(done_d), .err_count_o(err_d), .err_sat_o(sat_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed %0h, expected value missing from scoreboard", tag, obs);
    end else begin
      check(tag, obs, sb_q.pop_front());
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic push_lfsr(input int n);
    logic [31:0] s;
    s = SEED;
    for (int k = 0; k < n; k++) begin
      sb_q.push_back({24'h0, s[7:0]});
      s = lfsr_step(s);
    end
  endtask

  // With in stuck at 0, in_s is 0 and each compared cycle c sees the pattern shown at c-SS.
  function automatic int lfsr_miss(input int run_len);
    logic [31:0] s;
    logic [7:0]  pat [64];
    int          n;
    s = SEED;
    n = 0;
    for (int k = 0; k < run_len; k++) begin
      pat[k] = s[7:0];
      s = lfsr_step(s);
    end
    for (int c = SS + 1; c < run_len; c++) if (pat[c-SS] != 8'h00) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; loop_en = 1'b0; in_drv = 8'h5A;
    #2;
    check("rst_tie_a", 32'(tie_a), 32'hFF);
    check("rst_out_b", 32'(out_b), 32'h00);
    check("rst_busy_b", 32'(busy_b), 32'h0);
    check("rst_done_b", 32'(done_b), 32'h0);
    check("rst_err_c", 32'(err_c), 32'h0);
    repeat (3) tick();
    check("rst_tie_b", 32'(tie_b), 32'hFF);
    check("rst_out_a", 32'(out_a), 32'h00);
    rst_n = 1'b1;
    in_drv = 8'h00;
    repeat (4) tick();
    check("idle_inv0", 32'(out_b), 32'hFF);
    in_drv = 8'h5A;
    tick(); tick();
    check("idle_lat2", 32'(out_b), 32'hFF);
    tick();
    check("idle_lat3", 32'(out_b), 32'hA5);
    check("idle_tie", 32'(tie_c), 32'hFF);
    check("idle_busy", 32'(busy_b), 32'h0);
    check("idle_done", 32'(done_b), 32'h0);

    // Walking one on u_a, with a stray start and mode change mid-run.
    for (int k = 0; k < 10; k++) sb_q.push_back(32'h1 << (k % 8));
    pulse_start(2'b01);
    for (int c = 0; c < 10; c++) begin
      sb_check("walk_out", 32'(out_a));
      check("walk_busy", 32'(busy_a), 32'h1);
      if (c == 0) check("len1_busy", 32'(busy_d), 32'h1);
      if (c == 0) check("len1_out", 32'(out_d), 32'h01);
      if (c == 1) check("len1_done", 32'(done_d), 32'h1);
      if (c == 1) check("len1_idle_out", 32'(out_d), 32'h00);
      start = (c == 4);
      mode  = (c == 4) ? 2'b10 : 2'b01;
      tick();
    end
    check("walk_end_busy", 32'(busy_a), 32'h0);
    check("walk_end_done", 32'(done_a), 32'h1);
    check("walk_end_out", 32'(out_a), 32'h00);
    check("walk_end_err", 32'(err_a), 32'h0);
    guard = 0;
    while (busy_b && guard < 100) begin
      tick();
      guard++;
    end
    check("walk_b_finish", 32'(busy_b), 32'h0);

    // LFSR mode on u_b.
    push_lfsr(64);
    pulse_start(2'b10);
    for (int c = 0; c < 64; c++) begin
      if (c == 0) check("lfsr_first", 32'(out_b), 32'h01);
      if (c == 1) check("lfsr_second", 32'(out_b), 32'h03);
      sb_check("lfsr_out", 32'(out_b));
      check("lfsr_busy", 32'(busy_b), 32'h1);
      tick();
    end
    check("lfsr_done", 32'(done_b), 32'h1);
    check("lfsr_busy_end", 32'(busy_b), 32'h0);
    check("lfsr_out_end", 32'(out_b), 32'h00);
    check("lfsr_err", 32'(err_b), 32'h0);

    // CHECK mode with loopback: no mismatches expected anywhere.
    loop_en = 1'b1;
    pulse_start(2'b11);
    repeat (64) tick();
    check("loop_done", 32'(done_b), 32'h1);
    check("loop_err_b", 32'(err_b), 32'h0);
    check("loop_sat_b", 32'(sat_b), 32'h0);
    check("loop_err_c", 32'(err_c), 32'h0);
    check("loop_sat_c", 32'(sat_c), 32'h0);
    check("loop_err_a", 32'(err_a), 32'h0);

    // CHECK mode with in stuck at zero.
    loop_en = 1'b0;
    in_drv  = 8'h00;
    repeat (4) tick();
    m64 = lfsr_miss(64);
    m10 = lfsr_miss(10);
    pulse_start(2'b11);
    repeat (64) tick();
    check("stuck_err_b", 32'(err_b), 32'((m64 > 255) ? 255 : m64));
    check("stuck_sat_b", 32'(sat_b), 32'((m64 >= 255) ? 1 : 0));
    check("stuck_err_c", 32'(err_c), 32'((m64 > 15) ? 15 : m64));
    check("stuck_sat_c", 32'(sat_c), 32'((m64 >= 15) ? 1 : 0));
    check("stuck_err_a", 32'(err_a), 32'(m10));
    check("stuck_err_len1", 32'(err_d), 32'h0);
    check("stuck_sat_len1", 32'(sat_d), 32'h0);

    // Restart from DONE clears the counters and reseeds; reset lands mid-run.
    push_lfsr(64);
    pulse_start(2'b10);
    check("restart_err_c", 32'(err_c), 32'h0);
    check("restart_sat_c", 32'(sat_c), 32'h0);
    check("restart_done_c", 32'(done_c), 32'h0);
    check("restart_busy_c", 32'(busy_c), 32'h1);
    for (int c = 0; c < 6; c++) begin
      sb_check("rerun_out", 32'(out_b));
      if (c < 5) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_b", 32'(out_b), 32'h00);
    check("arst_busy_b", 32'(busy_b), 32'h0);
    check("arst_done_b", 32'(done_b), 32'h0);
    check("arst_out_a", 32'(out_a), 32'h00);
    check("arst_tie_b", 32'(tie_b), 32'hFF);
    sb_q.delete();
    in_drv = 8'h3C;
    #3 rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_out_b", 32'(out_b), 32'hC3);
    check("post_rst_out_a", 32'(out_a), 32'hC3);
    check("post_rst_busy", 32'(busy_b), 32'h0);
    check("post_rst_done", 32'(done_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pin_test_array.md
Name: pin_test_array

Overview:
- Parametrised multi-channel I/O test block for pin-placement and LVS regression designs.
- Generalises a single inverter with tie-off outputs to WIDTH channels.
- Adds input synchronisation, a registered inverting path, and a start-triggered pattern engine. The engine generates walking-one and LFSR patterns and runs a loopback check with a saturating error counter.
- Each output pin carries a distinct, checkable value, so a mis-tied or misaligned pin shows up as an LVS or functional failure.

Parameters:
- WIDTH, 8, number of test channels (legal 2..32).
- SYNC_STAGES, 2, depth of the input synchroniser flops per channel (legal >=1).
- RUN_LEN, 64, number of cycles spent in RUN per start (legal 1..65535).
- CNT_W, 8, error counter width (legal 1..16).
- LFSR_SEED, 32'hACE1_0001, 32-bit LFSR reset/start value (must be nonzero).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  test input pins; asynchronous to clk.
- mode  input  2  pattern mode; sampled only on an accepted start.
- start  input  1  single-cycle request to begin a run.
- out  output  WIDTH  test output pins.
- tied_to_one  output  WIDTH  constant all-ones; must never be driven to 0.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE until the next accepted start.
- err_count  output  CNT_W  mismatch count of the last CHECK run.
- err_sat  output  1  sticky flag: err_count reached all-ones during the current or last run.

Behaviour:
- Reset (rst_n low, async): all synchroniser flops 0, out=0, busy=0, done=0, err_count=0, err_sat=0, lfsr=LFSR_SEED, state=IDLE, latched mode=00. tied_to_one is combinational constant ones, also during reset.
- Synchroniser: in_s = in delayed through SYNC_STAGES flops.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> DONE when the cycle counter reaches RUN_LEN-1.
  - DONE -> RUN on start.
  - start during RUN is ignored. mode changes during RUN are ignored.
- On an accepted start:
  - latch mode; clear cycle counter, err_count and err_sat; reload lfsr=LFSR_SEED; walk register=1 (bit0).
  - busy rises on the next cycle.
- out by state (registered, updated every cycle):
  - IDLE: out = ~in_s. Total latency in->out is SYNC_STAGES+1 cycles.
  - RUN, mode 00 INVERT: out = ~in_s.
  - RUN, mode 01 WALK: out = walk register. The register rotates left by 1 each cycle, bit WIDTH-1 wraps to bit0. The first RUN cycle shows 1.
  - RUN, mode 10 LFSR: out = lfsr[WIDTH-1:0].
    - Fibonacci LFSR, taps 32,22,2,1.
    - Shift left; new bit0 = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0].
    - Advances once per RUN cycle. The first RUN cycle shows the seed bits.
  - RUN, mode 11 CHECK: out driven as in LFSR mode.
    - A delay line of SYNC_STAGES+1 entries holds past out values.
    - Each RUN cycle with counter >= SYNC_STAGES+1 compares in_s to out emitted SYNC_STAGES+1 cycles earlier. Earlier cycles are fill and are masked.
    - Any bit differing counts as one mismatch; err_count increments by 1.
  - DONE: out=0, done=1, busy=0. err_count and err_sat hold.
- err_count saturates at 2^CNT_W-1 with no wrap; err_sat sets when that value is reached.
- err_count is cleared only by reset or an accepted start. In non-CHECK modes it stays 0.
- Reset asserted mid-RUN: immediate return to reset values. No partial result is retained.
- RUN_LEN=1: RUN lasts exactly one cycle. In CHECK with SYNC_STAGES+1 > RUN_LEN, nothing is compared and err_count=0.

Test Plan:
- Reset then IDLE, WIDTH=8, SYNC_STAGES=2: drive in=8'h5A -> out=8'hA5 exactly 3 cycles later; tied_to_one=8'hFF throughout, including during reset; busy=0, done=0.
- start with mode=01, RUN_LEN=10: out sequence 01,02,04,...,80,01,02 over 10 cycles -> busy high 10 cycles, then done=1, out=00.
- start with mode=10: first out = 8'h01 (seed low byte), second = 8'h03 (seed shifted, new bit 1) -> matches the reference LFSR model for all 64 cycles.
- start mode=11 with external loopback in=out, RUN_LEN=64 -> err_count=0, err_sat=0. Repeat with in stuck at 8'h00 -> err_count = count of non-zero delayed patterns among cycles 3..63; with CNT_W=4 it saturates at 15 and err_sat=1.
- start pulsed again mid-RUN and mode toggled mid-RUN -> run length and pattern unchanged. Reset asserted at RUN cycle 5 -> all outputs at reset values asynchronously, state IDLE.
- DONE then a new start -> err_count and err_sat cleared on the start cycle edge, lfsr reseeded; out sequence identical to the first run.
